// File: rtl/sys_ctrl_rx_decoder_pkg.sv
// Shared definitions for the system-control receive decoder: command opcodes,
// FSM state encoding and the register-file slots that hold ALU operands.
package sys_ctrl_rx_decoder_pkg;

    localparam logic [7:0] CMD_REG_WR  = 8'hAA;
    localparam logic [7:0] CMD_REG_RD  = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        FUN,
        ALU_WAIT,
        RSP_LO,
        RSP_HI
    } state_t;

endpackage

// File: rtl/sys_ctrl_rx_decoder.sv
// Parses UART command frames into register-file / ALU requests and returns
// read data or the ALU result one byte at a time over a valid/ready handshake.
module sys_ctrl_rx_decoder
    import sys_ctrl_rx_decoder_pkg::*;
#(
    parameter int Data_width = 8,
    parameter int Addr_width = 4,
    parameter int Fun_width  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [Data_width-1:0]   RX_P_DATA,
    input  logic                    RX_data_valid,
    output logic [Addr_width-1:0]   Address,
    output logic [Data_width-1:0]   WrData,
    output logic                    WrEn,
    output logic                    RdEn,
    input  logic [Data_width-1:0]   RdData,
    input  logic                    RdData_Valid,
    output logic [Fun_width-1:0]    ALU_FUN,
    output logic                    ALU_EN,
    output logic                    CLK_GATE_EN,
    input  logic [2*Data_width-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic [Data_width-1:0]   rsp_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    cmd_err,
    output logic                    rx_overrun
);

    state_t                  state;
    logic [Data_width-1:0]   result_hi;
    logic                    two_beat;
    logic                    busy;

    // States in which an incoming byte cannot be consumed.
    always_comb begin
        busy = (state == RD_WAIT) || (state == ALU_WAIT) ||
               (state == RSP_LO)  || (state == RSP_HI);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            Address     <= '0;
            WrData      <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            rsp_data    <= '0;
            rsp_valid   <= 1'b0;
            cmd_err     <= 1'b0;
            rx_overrun  <= 1'b0;
            result_hi   <= '0;
            two_beat    <= 1'b0;
        end else begin
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            ALU_EN     <= 1'b0;
            cmd_err    <= 1'b0;
            rx_overrun <= RX_data_valid && busy;

            case (state)
                IDLE: begin
                    if (RX_data_valid) begin
                        case (RX_P_DATA)
                            Data_width'(CMD_REG_WR): state <= WR_ADDR;
                            Data_width'(CMD_REG_RD): state <= RD_ADDR;
                            Data_width'(CMD_ALU_OP): state <= OP_A;
                            Data_width'(CMD_ALU_NOP): begin
                                state       <= FUN;
                                CLK_GATE_EN <= 1'b1;
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end
                WR_ADDR: begin
                    if (RX_data_valid) begin
                        Address <= RX_P_DATA[Addr_width-1:0];
                        state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_data_valid) begin
                        WrData <= RX_P_DATA;
                        WrEn   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (RX_data_valid) begin
                        Address <= RX_P_DATA[Addr_width-1:0];
                        RdEn    <= 1'b1;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (RdData_Valid) begin
                        rsp_data  <= RdData;
                        rsp_valid <= 1'b1;
                        result_hi <= '0;
                        two_beat  <= 1'b0;
                        state     <= RSP_LO;
                    end
                end
                OP_A: begin
                    if (RX_data_valid) begin
                        Address <= Addr_width'(OPA_ADDR);
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state   <= OP_B;
                    end
                end
                OP_B: begin
                    if (RX_data_valid) begin
                        Address     <= Addr_width'(OPB_ADDR);
                        WrData      <= RX_P_DATA;
                        WrEn        <= 1'b1;
                        CLK_GATE_EN <= 1'b1;
                        state       <= FUN;
                    end
                end
                FUN: begin
                    if (RX_data_valid) begin
                        ALU_FUN <= RX_P_DATA[Fun_width-1:0];
                        ALU_EN  <= 1'b1;
                        state   <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        rsp_data    <= ALU_OUT[Data_width-1:0];
                        result_hi   <= ALU_OUT[2*Data_width-1:Data_width];
                        rsp_valid   <= 1'b1;
                        two_beat    <= 1'b1;
                        CLK_GATE_EN <= 1'b0;
                        state       <= RSP_LO;
                    end
                end
                // rsp_data only changes on a transfer, so it is stable while stalled.
                RSP_LO: begin
                    if (rsp_ready) begin
                        if (two_beat) begin
                            rsp_data <= result_hi;
                            state    <= RSP_HI;
                        end else begin
                            rsp_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                RSP_HI: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
// Directed bench for sys_ctrl_rx_decoder: write, read, ALU frames, overrun,
// illegal opcode and asynchronous reset in the middle of a frame.
module tb_sys_ctrl_rx_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_data_valid = 1'b0;
    logic [3:0]  Address;
    logic [7:0]  WrData;
    logic        WrEn;
    logic        RdEn;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic        CLK_GATE_EN;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        cmd_err;
    logic        rx_overrun;

    int total = 0;
    int bad   = 0;

    int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, ovr_cnt = 0, rspv_cnt = 0, viol = 0;
    logic prev_pulse = 1'b0;

    sys_ctrl_rx_decoder #(.Data_width(8), .Addr_width(4), .Fun_width(4)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_data_valid(RX_data_valid),
        .Address(Address), .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .cmd_err(cmd_err), .rx_overrun(rx_overrun)
    );

    always #5 CLK = ~CLK;

    // Pulse counters and strobe exclusivity watch.
    always @(posedge CLK) begin
        if (WrEn)       wr_cnt   <= wr_cnt + 1;
        if (RdEn)       rd_cnt   <= rd_cnt + 1;
        if (ALU_EN)     alu_cnt  <= alu_cnt + 1;
        if (rx_overrun) ovr_cnt  <= ovr_cnt + 1;
        if (rsp_valid)  rspv_cnt <= rspv_cnt + 1;
        if ((int'(WrEn) + int'(RdEn) + int'(ALU_EN)) > 1) viol <= viol + 1;
        if (prev_pulse && (WrEn || RdEn || ALU_EN)) viol <= viol + 1;
        prev_pulse <= WrEn || RdEn || ALU_EN;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA     = b;
        RX_data_valid = 1'b1;
        @(negedge CLK);
        RX_data_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, Address, WrData, WrEn, RdEn, ALU_FUN, ALU_EN, CLK_GATE_EN,
                rsp_data, rsp_valid, cmd_err, rx_overrun};
    endfunction

    int w0, r0, a0, o0, v0;

    initial begin
        gap(3);
        check("reset_outputs", all_outs(), 32'h0);
        RST = 1'b1;
        gap(2);

        // Register write
        w0 = wr_cnt; v0 = rspv_cnt;
        send_byte(8'hAA); gap(2);
        send_byte(8'h05); gap(2);
        send_byte(8'h3C);
        check("wr_en", {31'b0, WrEn}, 32'h1);
        check("wr_addr", {28'b0, Address}, 32'h5);
        check("wr_data", {24'b0, WrData}, 32'h3C);
        gap(3);
        check("wr_pulse_count", wr_cnt - w0, 32'd1);
        check("wr_no_rsp", rspv_cnt - v0, 32'd0);

        // Register read with data returned two cycles after RdEn
        r0 = rd_cnt;
        send_byte(8'hBB); gap(2);
        send_byte(8'h05);
        check("rd_en", {31'b0, RdEn}, 32'h1);
        check("rd_addr", {28'b0, Address}, 32'h5);
        gap(1);
        RdData = 8'h3C; RdData_Valid = 1'b1;
        gap(1);
        RdData_Valid = 1'b0;
        check("rd_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("rd_rsp_data", {24'b0, rsp_data}, 32'h3C);
        rsp_ready = 1'b1;
        gap(1);
        rsp_ready = 1'b0;
        check("rd_rsp_done", {31'b0, rsp_valid}, 32'h0);
        check("rd_pulse_count", rd_cnt - r0, 32'd1);

        // ALU with operands, stalled response
        send_byte(8'hCC); gap(2);
        send_byte(8'h10);
        check("opa_wr", {23'b0, WrEn, Address, WrData[3:0]}, {23'b0, 1'b1, 4'h0, 4'h0});
        check("opa_data", {24'b0, WrData}, 32'h10);
        gap(2);
        send_byte(8'h20);
        check("opb_wr", {27'b0, WrEn, Address}, {27'b0, 1'b1, 4'h1});
        check("opb_data", {24'b0, WrData}, 32'h20);
        check("opb_gate", {31'b0, CLK_GATE_EN}, 32'h1);
        gap(2);
        send_byte(8'h00);
        check("alu_en", {27'b0, ALU_EN, ALU_FUN}, {27'b0, 1'b1, 4'h0});
        check("alu_gate", {31'b0, CLK_GATE_EN}, 32'h1);
        gap(1);
        ALU_OUT = 16'h0030; ALU_OUT_VLD = 1'b1;
        gap(1);
        ALU_OUT_VLD = 1'b0;
        check("alu_gate_off", {31'b0, CLK_GATE_EN}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("alu_lo_stall", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, 8'h30});
            gap(1);
        end
        rsp_ready = 1'b1;
        gap(1);
        check("alu_hi", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, 8'h00});
        gap(1);
        rsp_ready = 1'b0;
        check("alu_rsp_done", {31'b0, rsp_valid}, 32'h0);

        // ALU without operands, overrun while waiting, back-to-back response
        w0 = wr_cnt; a0 = alu_cnt; o0 = ovr_cnt;
        send_byte(8'hDD);
        check("nop_gate", {31'b0, CLK_GATE_EN}, 32'h1);
        gap(2);
        send_byte(8'h02);
        check("nop_alu_en", {27'b0, ALU_EN, ALU_FUN}, {27'b0, 1'b1, 4'h2});
        gap(2);
        send_byte(8'h77);
        check("overrun_pulse", {31'b0, rx_overrun}, 32'h1);
        gap(2);
        check("nop_no_wr", wr_cnt - w0, 32'd0);
        check("nop_one_alu", alu_cnt - a0, 32'd1);
        check("overrun_count", ovr_cnt - o0, 32'd1);
        ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
        gap(1);
        ALU_OUT_VLD = 1'b0;
        check("nop_lo", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, 8'h34});
        rsp_ready = 1'b1;
        gap(1);
        check("nop_hi", {23'b0, rsp_valid, rsp_data}, {23'b0, 1'b1, 8'h12});
        gap(1);
        rsp_ready = 1'b0;
        check("nop_done", {31'b0, rsp_valid}, 32'h0);

        // Illegal opcode then a normal write frame
        send_byte(8'h55);
        check("cmd_err", {31'b0, cmd_err}, 32'h1);
        gap(1);
        check("cmd_err_pulse", {31'b0, cmd_err}, 32'h0);
        send_byte(8'hAA); gap(2);
        send_byte(8'h0A); gap(2);
        send_byte(8'h5A);
        check("post_err_wr", {19'b0, WrEn, Address, WrData}, {19'b0, 1'b1, 4'hA, 8'h5A});

        // Asynchronous reset while waiting for read data
        send_byte(8'hBB); gap(2);
        send_byte(8'h05);
        gap(1);
        #2 RST = 1'b0;
        #1 check("async_reset", all_outs(), 32'h0);
        gap(1);
        RST = 1'b1;
        v0 = rspv_cnt;
        RdData = 8'h99; RdData_Valid = 1'b1;
        gap(1);
        RdData_Valid = 1'b0;
        gap(3);
        check("reset_discard", rspv_cnt - v0, 32'd0);

        check("strobe_exclusive", viol, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
